// File: rtl/esm_issue_ctrl.sv
// esm_issue_ctrl: instruction-buffer slot owner for the ESM dependency path.
// Allocates slots, stores dependency rows, offers ready slots, retires completions.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alloc_req       new instruction wants a slot
//   alloc_dep       dependency row (bit j: waits on slot j)
//   alloc_gnt       request accepted this cycle (combinational)
//   alloc_index     granted slot (lowest free), valid with alloc_gnt
//   full            no free slot (combinational)
//   issue_valid     registered offer of a ready slot
//   issue_index     registered offered slot
//   issue_ready     execute stage takes the offer
//   cmpl_valid      a slot finished
//   cmpl_index      finished slot
//   occ_count       number of non-free slots (registered)
//   err             sticky: completion hit a slot that was not issued
module esm_issue_ctrl #(
    parameter int bs = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    input  logic [bs-1:0]            alloc_dep,
    output logic                     alloc_gnt,
    output logic [$clog2(bs)-1:0]    alloc_index,
    output logic                     full,
    output logic                     issue_valid,
    output logic [$clog2(bs)-1:0]    issue_index,
    input  logic                     issue_ready,
    input  logic                     cmpl_valid,
    input  logic [$clog2(bs)-1:0]    cmpl_index,
    output logic [$clog2(bs):0]      occ_count,
    output logic                     err
);

    localparam int bs_bits = $clog2(bs);

    typedef enum logic [1:0] {
        S_FREE,
        S_WAIT,
        S_ISSUED
    } slot_st_e;

    slot_st_e           state_q [bs];
    slot_st_e           state_d [bs];
    logic [bs-1:0]      dep_q   [bs];
    logic [bs-1:0]      dep_d   [bs];

    logic               issue_valid_q, issue_valid_d;
    logic [bs_bits-1:0] issue_index_q, issue_index_d;
    logic [bs_bits:0]   occ_count_q, occ_count_d;
    logic               err_q, err_d;

    logic [bs-1:0]      free_vec;
    logic [bs-1:0]      elig_vec;
    logic [bs-1:0]      own_mask;
    logic [bs-1:0]      cmpl_mask;
    logic [bs-1:0]      alloc_row;
    logic [bs_bits-1:0] free_idx;
    logic [bs_bits-1:0] pick_idx;
    logic               pick_any;
    logic               hs;
    logic               cmpl_ok;

    assign hs      = issue_valid_q & issue_ready;
    assign cmpl_ok = cmpl_valid & (state_q[cmpl_index] == S_ISSUED);

    // Slot classification and lowest-index selection.
    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        for (int i = 0; i < bs; i++) begin
            free_vec[i] = (state_q[i] == S_FREE);
            elig_vec[i] = (state_q[i] == S_WAIT) && (dep_q[i] == '0);
        end
        // The slot leaving on this cycle's handshake must not be re-offered.
        if (hs) begin
            elig_vec[issue_index_q] = 1'b0;
        end

        free_idx = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = bs_bits'(i);
            end
            if (elig_vec[i]) begin
                pick_idx = bs_bits'(i);
                pick_any = 1'b1;
            end
        end
    end

    assign full        = ~|free_vec;
    assign alloc_gnt   = alloc_req & ~full;
    assign alloc_index = free_idx;

    // Free slots cannot be producers; a producer completing this very
    // cycle is forwarded so the new row never waits on a dead slot.
    always_comb begin
        own_mask  = '0;
        cmpl_mask = '0;
        own_mask[free_idx] = 1'b1;
        if (cmpl_valid) begin
            cmpl_mask[cmpl_index] = 1'b1;
        end
        alloc_row = alloc_dep & ~free_vec & ~own_mask & ~cmpl_mask;
    end

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i];
            if (cmpl_ok) begin
                dep_d[i][cmpl_index] = 1'b0;
            end
        end

        if (cmpl_ok) begin
            state_d[cmpl_index] = S_FREE;
        end
        if (hs) begin
            state_d[issue_index_q] = S_ISSUED;
        end
        // Alloc row is written after the column clear so forwarding wins.
        if (alloc_gnt) begin
            state_d[free_idx] = S_WAIT;
            dep_d[free_idx]   = alloc_row;
        end

        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        if (!issue_valid_q || hs) begin
            issue_valid_d = pick_any;
            issue_index_d = pick_idx;
        end

        occ_count_d = occ_count_q
                    + (bs_bits + 1)'(alloc_gnt)
                    - (bs_bits + 1)'(cmpl_ok);
        err_d       = err_q | (cmpl_valid & ~cmpl_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= S_FREE;
                dep_q[i]   <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            occ_count_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            occ_count_q   <= occ_count_d;
            err_q         <= err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign occ_count   = occ_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_esm_issue_ctrl.sv
// tb_esm_issue_ctrl: directed bench for esm_issue_ctrl (bs=4).
// Slot-level reference model compared every cycle, plus literal spot checks.
module tb_esm_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic [3:0] alloc_dep;
    logic       alloc_gnt;
    logic [1:0] alloc_index;
    logic       full;
    logic       issue_valid;
    logic [1:0] issue_index;
    logic       issue_ready;
    logic       cmpl_valid;
    logic [1:0] cmpl_index;
    logic [2:0] occ_count;
    logic       err;

    int checks   = 0;
    int failures = 0;

    esm_issue_ctrl #(.bs(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_dep   (alloc_dep),
        .alloc_gnt   (alloc_gnt),
        .alloc_index (alloc_index),
        .full        (full),
        .issue_valid (issue_valid),
        .issue_index (issue_index),
        .issue_ready (issue_ready),
        .cmpl_valid  (cmpl_valid),
        .cmpl_index  (cmpl_index),
        .occ_count   (occ_count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: slot status 0=free 1=waiting 2=issued,
    // waits-on set per slot, the current offer and the sticky error.
    int       mst [4];
    bit [3:0] mw  [4];
    bit       mv;
    int       mi;
    bit       merr;
    bit       minit = 1'b0;

    always @(negedge clk) begin : model
        int       nfree;
        int       aidx;
        int       pick;
        int       ci;
        bit       gnt;
        bit       hs;
        bit       cok;
        bit [3:0] row;

        nfree = 0;
        aidx  = -1;
        for (int i = 0; i < 4; i++) begin
            if (mst[i] == 0) begin
                nfree++;
                if (aidx < 0) aidx = i;
            end
        end
        gnt = alloc_req && (nfree > 0);

        if (minit) begin
            chk("cyc_full", int'(full), int'(nfree == 0));
            chk("cyc_gnt", int'(alloc_gnt), int'(gnt));
            if (gnt) chk("cyc_aidx", int'(alloc_index), aidx);
            chk("cyc_occ", int'(occ_count), 4 - nfree);
            chk("cyc_err", int'(err), int'(merr));
            chk("cyc_ivalid", int'(issue_valid), int'(mv));
            if (mv) chk("cyc_iidx", int'(issue_index), mi);
        end

        hs = mv && issue_ready;
        ci = int'(cmpl_index);
        cok = cmpl_valid && (mst[ci] == 2);
        pick = -1;
        for (int i = 0; i < 4; i++) begin
            if (pick < 0 && mst[i] == 1 && mw[i] == 4'b0 && !(hs && i == mi))
                pick = i;
        end
        row = 4'b0;
        for (int j = 0; j < 4; j++) begin
            row[j] = alloc_dep[j] && (mst[j] != 0) && (j != aidx)
                   && !(cmpl_valid && j == ci);
        end

        if (cok) begin
            for (int i = 0; i < 4; i++) mw[i][ci] = 1'b0;
            mst[ci] = 0;
        end
        if (hs) mst[mi] = 2;
        if (gnt) begin
            mst[aidx] = 1;
            mw[aidx]  = row;
        end
        if (cmpl_valid && !cok) merr = 1'b1;
        if (!mv || hs) begin
            mv = (pick >= 0);
            mi = (pick >= 0) ? pick : 0;
        end

        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mst[i] = 0;
                mw[i]  = 4'b0;
            end
            mv    = 1'b0;
            mi    = 0;
            merr  = 1'b0;
            minit = 1'b1;
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        alloc_req  = 1'b0;
        alloc_dep  = 4'b0;
        cmpl_valid = 1'b0;
        cmpl_index = 2'd0;
    endtask

    task automatic do_rst;
        rst = 1'b1;
        clr();
        issue_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue_ready = 1'b0;
        clr();

        // Reset for two cycles, then first allocation.
        cyc();
        cyc();
        chk("rst_ivalid", int'(issue_valid), 0);
        chk("rst_occ", int'(occ_count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        alloc_req = 1'b1;
        #1;
        chk("t1_gnt", int'(alloc_gnt), 1);
        chk("t1_idx", int'(alloc_index), 0);

        // Fill all four slots.
        for (int k = 1; k < 4; k++) begin
            cyc();
            #1;
            chk("t2_idx", int'(alloc_index), k);
        end
        cyc();
        #1;
        chk("t2_full", int'(full), 1);
        chk("t2_occ", int'(occ_count), 4);
        chk("t2_gnt5", int'(alloc_gnt), 0);
        chk("t2_ivalid", int'(issue_valid), 1);
        chk("t2_iidx", int'(issue_index), 0);
        issue_ready = 1'b1;
        cyc();
        // Completion frees slot 0, but not allocatable in the same cycle.
        issue_ready = 1'b0;
        cmpl_valid = 1'b1;
        cmpl_index = 2'd0;
        #1;
        chk("t2_cmpl_gnt", int'(alloc_gnt), 0);
        chk("t2_next_offer", int'(issue_index), 1);
        cyc();
        cmpl_valid = 1'b0;
        #1;
        chk("t2_realloc_gnt", int'(alloc_gnt), 1);
        chk("t2_realloc_idx", int'(alloc_index), 0);
        chk("t2_occ3", int'(occ_count), 3);
        cyc();
        alloc_req = 1'b0;
        #1;
        chk("t2_occ4", int'(occ_count), 4);
        do_rst();

        // Chain: slot1 waits on slot0.
        issue_ready = 1'b1;
        alloc_req = 1'b1;
        alloc_dep = 4'b0000;
        cyc();
        alloc_dep = 4'b0001;
        cyc();
        clr();
        #1;
        chk("t3_off0_v", int'(issue_valid), 1);
        chk("t3_off0_i", int'(issue_index), 0);
        cyc();
        #1;
        chk("t3_blocked", int'(issue_valid), 0);
        cmpl_valid = 1'b1;
        cmpl_index = 2'd0;
        cyc();
        cmpl_valid = 1'b0;
        #1;
        chk("t3_t1_none", int'(issue_valid), 0);
        cyc();
        #1;
        chk("t3_t2_v", int'(issue_valid), 1);
        chk("t3_t2_i", int'(issue_index), 1);
        do_rst();

        // Forwarding: alloc depending on a slot completing this cycle.
        issue_ready = 1'b1;
        alloc_req = 1'b1;
        cyc();
        alloc_req = 1'b0;
        cyc();
        #1;
        chk("t4_off0", int'(issue_valid), 1);
        cyc();
        issue_ready = 1'b0;
        #1;
        chk("t4_issued", int'(issue_valid), 0);
        cmpl_valid = 1'b1;
        cmpl_index = 2'd0;
        alloc_req = 1'b1;
        alloc_dep = 4'b0001;
        #1;
        chk("t4_gnt", int'(alloc_gnt), 1);
        chk("t4_idx", int'(alloc_index), 1);
        cyc();
        clr();
        #1;
        chk("t4_t1_none", int'(issue_valid), 0);
        chk("t4_occ", int'(occ_count), 1);
        cyc();
        #1;
        chk("t4_t2_v", int'(issue_valid), 1);
        chk("t4_t2_i", int'(issue_index), 1);
        do_rst();

        // Backpressure: offer of slot 2 held while slot 1 becomes ready.
        alloc_req = 1'b1;
        alloc_dep = 4'b0000;
        cyc();
        alloc_dep = 4'b0001;
        cyc();
        alloc_dep = 4'b0000;
        cyc();
        clr();
        #1;
        chk("t5_occ", int'(occ_count), 3);
        chk("t5_off0", int'(issue_index), 0);
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        #1;
        chk("t5_off2_v", int'(issue_valid), 1);
        chk("t5_off2_i", int'(issue_index), 2);
        cmpl_valid = 1'b1;
        cmpl_index = 2'd0;
        cyc();
        cmpl_valid = 1'b0;
        #1;
        chk("t5_hold", int'(issue_index), 2);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("t5_hold", int'(issue_index), 2);
        end
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        #1;
        chk("t5_next_v", int'(issue_valid), 1);
        chk("t5_next_i", int'(issue_index), 1);

        // Error on a waiting slot, then reset mid-flight.
        cmpl_valid = 1'b1;
        cmpl_index = 2'd1;
        cyc();
        cmpl_valid = 1'b0;
        #1;
        chk("t6_err", int'(err), 1);
        chk("t6_occ", int'(occ_count), 2);
        chk("t6_keep_i", int'(issue_index), 1);
        cyc();
        cyc();
        #1;
        chk("t6_sticky", int'(err), 1);
        alloc_req = 1'b1;
        #1;
        chk("t6_aidx", int'(alloc_index), 0);
        cyc();
        alloc_req = 1'b0;
        #1;
        chk("t6_occ3", int'(occ_count), 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_rst_occ", int'(occ_count), 0);
        chk("t6_rst_err", int'(err), 0);
        chk("t6_rst_iv", int'(issue_valid), 0);
        chk("t6_rst_full", int'(full), 0);
        alloc_req = 1'b1;
        #1;
        chk("t6_post_idx", int'(alloc_index), 0);
        cyc();
        clr();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
